// File: rtl/vga_scan_out.sv
// VGA scan generator and output stage: timing counters, registered address/sync stage,
// latency-matching delay line and masked colour output. Define TEST_PATTERN_EN for colour bars.
module vga_scan_out #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SRC_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_in,
  input  logic [11:0] mask,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        rdn,
  output logic        clk_frame,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYN_S = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYN_E = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYN_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYN_E = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       active;
  logic       h_sync;
  logic       v_sync;

  // Index 0 is the address-stage register; higher indices delay it toward the pixel return.
  logic [SRC_LAT:0] rdn_p;
  logic [SRC_LAT:0] hs_p;
  logic [SRC_LAT:0] vs_p;
  logic [11:0]      pix_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    h_sync = (h_cnt >= H_SYN_S) && (h_cnt < H_SYN_E);
    v_sync = (v_cnt >= V_SYN_S) && (v_cnt < V_SYN_E);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_addr  <= '0;
      row_addr  <= '0;
      clk_frame <= 1'b0;
      rdn_p     <= '1;
      hs_p      <= '1;
      vs_p      <= '1;
    end else begin
      col_addr  <= active ? h_cnt : '0;
      row_addr  <= active ? v_cnt[8:0] : '0;
      clk_frame <= (v_cnt >= V_ACT);
      rdn_p[0]  <= ~active;
      hs_p[0]   <= ~h_sync;
      vs_p[0]   <= ~v_sync;
      for (int unsigned i = 1; i <= SRC_LAT; i++) begin
        rdn_p[i] <= rdn_p[i-1];
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
      end
    end
  end

  assign rdn = rdn_p[0];

`ifdef TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [9:0] col_p [SRC_LAT:0];
  logic [2:0] bar_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= SRC_LAT; i++) col_p[i] <= '0;
    end else begin
      col_p[0] <= active ? h_cnt : '0;
      for (int unsigned i = 1; i <= SRC_LAT; i++) col_p[i] <= col_p[i-1];
    end
  end

  always_comb begin
    bar_sel = 3'(col_p[SRC_LAT] / BAR_W);
    pix_src = 12'h000;
    case (bar_sel)
      3'd0: pix_src = 12'hFFF;
      3'd1: pix_src = 12'hFF0;
      3'd2: pix_src = 12'h0FF;
      3'd3: pix_src = 12'h0F0;
      3'd4: pix_src = 12'hF0F;
      3'd5: pix_src = 12'hF00;
      3'd6: pix_src = 12'h00F;
      default: pix_src = 12'h000;
    endcase
  end
`else
  assign pix_src = pixel_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      {r, g, b} <= '0;
      hs        <= 1'b1;
      vs        <= 1'b1;
    end else begin
      {r, g, b} <= rdn_p[SRC_LAT] ? 12'h000 : (pix_src & mask);
      hs        <= hs_p[SRC_LAT];
      vs        <= vs_p[SRC_LAT];
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench for vga_scan_out on a scaled-down raster (50 clocks x 19 lines) so whole
// frames fit in a short run; SRC_LAT=1 renderer model returns a column-based ramp.
module tb_vga_scan_out;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_in;
  logic [11:0] mask;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic        clk_frame;
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  int pix_mode = 0;
  logic [9:0] prev_col = '0;

  vga_scan_out #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SRC_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .mask(mask),
    .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn), .clk_frame(clk_frame),
    .hs(hs), .vs(vs), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ramp(input logic [9:0] col);
    return {~col[3:0], 4'h3, col[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Renderer model: returns the pixel for the address presented on the previous cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    case (pix_mode)
      0:       pixel_in = ramp(prev_col);
      1:       pixel_in = 12'hABC;
      default: pixel_in = 12'hFFF;
    endcase
    prev_col = col_addr;
  endtask

  task automatic run_to(input int n);
    while (t < n) tick();
  endtask

  initial begin
    int blank_nz, mask_nz, hs_low;
    int hs_f1, hs_f2, hs_r1;
    int vs_f1, vs_f2, vs_r1, cf_r1, cf_r2, cf_f1;
    logic p_hs, p_vs, p_cf;
    logic [8:0] cf_row;
    logic       cf_rdn;

    rst = 1'b1; mask = 12'hFFF; pixel_in = 12'h000;
    repeat (3) tick();
    check("rst_row", row_addr, 0);
    check("rst_col", col_addr, 0);
    check("rst_rdn", rdn, 1);
    check("rst_clk_frame", clk_frame, 0);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_rgb", {r, g, b}, 0);

    rst = 1'b0; t = 0; prev_col = '0;
    run_to(1);
    check("t1_col", col_addr, 0);
    check("t1_row", row_addr, 0);
    check("t1_rdn", rdn, 0);
    run_to(3);
    check("t3_rgb_col0", {r, g, b}, 12'hF30);
    check("t3_hs", hs, 1);
    run_to(6);
    check("t6_col", col_addr, 5);
    run_to(8);
    check("t8_rgb_col5", {r, g, b}, 12'hA35);
    run_to(34);
    check("t34_rgb_col31", {r, g, b}, 12'h03F);

    pix_mode = 2;
    blank_nz = 0;
    while (t < 52) begin
      tick();
      if ({r, g, b} != 12'h000) blank_nz++;
      if (t == 51) begin
        check("t51_row", row_addr, 1);
        check("t51_col", col_addr, 0);
        check("t51_rdn", rdn, 0);
      end
    end
    check("hblank_rgb_nonzero", blank_nz, 0);
    run_to(53);
    check("t53_rgb_fff", {r, g, b}, 12'hFFF);

    hs_f1 = 0; hs_f2 = 0; hs_r1 = 0; p_hs = hs;
    for (int i = 0; i < 300 && hs_f2 == 0; i++) begin
      tick();
      if (p_hs && !hs) begin
        if (hs_f1 == 0) hs_f1 = t; else hs_f2 = t;
      end
      if (!p_hs && hs && hs_f1 != 0 && hs_r1 == 0) hs_r1 = t;
      p_hs = hs;
    end
    check("hs_first_fall", hs_f1, 89);
    check("hs_period", hs_f2 - hs_f1, 50);
    check("hs_low_width", hs_r1 - hs_f1, 8);

    mask = 12'h000; pix_mode = 1;
    mask_nz = 0; hs_low = 0;
    repeat (100) begin
      tick();
      if ({r, g, b} != 12'h000) mask_nz++;
      if (!hs) hs_low++;
    end
    check("mask0_rgb_nonzero", mask_nz, 0);
    check("mask0_hs_low_2lines", hs_low, 16);
    mask = 12'hFFF; pix_mode = 0;

    vs_f1 = 0; vs_f2 = 0; vs_r1 = 0; cf_r1 = 0; cf_r2 = 0; cf_f1 = 0;
    cf_row = '1; cf_rdn = 1'b0;
    p_vs = vs; p_cf = clk_frame;
    for (int i = 0; i < 2500 && vs_f2 == 0; i++) begin
      tick();
      if (p_vs && !vs) begin
        if (vs_f1 == 0) vs_f1 = t; else vs_f2 = t;
      end
      if (!p_vs && vs && vs_f1 != 0 && vs_r1 == 0) vs_r1 = t;
      if (!p_cf && clk_frame) begin
        if (cf_r1 == 0) begin
          cf_r1 = t; cf_row = row_addr; cf_rdn = rdn;
        end else if (cf_r2 == 0) cf_r2 = t;
      end
      if (p_cf && !clk_frame && cf_r1 != 0 && cf_f1 == 0) cf_f1 = t;
      p_vs = vs; p_cf = clk_frame;
    end
    check("vs_fall_phase", vs_f1 % 950, 703);
    check("vs_period", vs_f2 - vs_f1, 950);
    check("vs_low_width", vs_r1 - vs_f1, 100);
    check("clk_frame_rise_phase", cf_r1 % 950, 601);
    check("clk_frame_period", cf_r2 - cf_r1, 950);
    check("clk_frame_high", cf_f1 - cf_r1, 350);
    check("clk_frame_rise_rdn", cf_rdn, 1);
    check("clk_frame_rise_row", cf_row, 0);

    run_to(2170);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_outputs",
            {row_addr, col_addr, rdn, clk_frame, hs, vs, r, g, b},
            {9'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000});
    end
    rst = 1'b0; t = 0; prev_col = '0;
    run_to(1);
    check("post_rst_row", row_addr, 0);
    check("post_rst_col", col_addr, 0);
    check("post_rst_rdn", rdn, 0);
    run_to(2);
    check("post_rst_col1", col_addr, 1);
    run_to(3);
    check("post_rst_rgb_col0", {r, g, b}, 12'hF30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
